// File: rtl/countdown_timer.sv
// Keypad-loaded MM:SS countdown timer.
// Digits shift in from the right while the timer is stopped; a prescaler
// divides clk into one-second ticks while counting, and timer_done is raised
// on the tick that reaches 00:00.
//
// state | meaning
// IDLE  | not counting (stopped, paused, or freshly loaded)
// RUN   | counting; prescaler advances every cycle spent in RUN
// DONE  | countdown reached 00:00, timer_done held until cleared or reloaded
module countdown_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clearn,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       timer_done
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] ps, ps_nxt;
  logic [3:0]    mt_nxt, mo_nxt, st_nxt, so_nxt;
  logic          done_nxt;
  logic          accept;
  logic          tick;
  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic          dec_zero;

  assign zero   = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign accept = digit_valid && (digit <= 4'd9) && !enable;
  // The !zero guard keeps the borrow chain from ever wrapping below 00:00.
  assign tick   = (state == RUN) && (ps == PS_LAST) && !zero;

  // Time value one second earlier, with seconds borrowing 9 then 5 from minutes.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_so = sec_ones - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_st = sec_tens - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones != 4'd0) begin
          dec_mo = min_ones - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
    dec_zero = (dec_mt == 4'd0) && (dec_mo == 4'd0) &&
               (dec_st == 4'd0) && (dec_so == 4'd0);
  end

  // Next state and next register values: clear > digit entry > counting.
  always_comb begin
    state_nxt = state;
    ps_nxt    = ps;
    mt_nxt    = min_tens;
    mo_nxt    = min_ones;
    st_nxt    = sec_tens;
    so_nxt    = sec_ones;
    done_nxt  = timer_done;
    if (!clearn) begin
      state_nxt = IDLE;
      ps_nxt    = '0;
      mt_nxt    = 4'd0;
      mo_nxt    = 4'd0;
      st_nxt    = 4'd0;
      so_nxt    = 4'd0;
      done_nxt  = 1'b0;
    end else if (accept) begin
      state_nxt = IDLE;
      mt_nxt    = min_ones;
      mo_nxt    = sec_tens;
      st_nxt    = sec_ones;
      so_nxt    = digit;
      done_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !zero) state_nxt = RUN;
        end
        RUN: begin
          if (tick) begin
            ps_nxt = '0;
            mt_nxt = dec_mt;
            mo_nxt = dec_mo;
            st_nxt = dec_st;
            so_nxt = dec_so;
            if (dec_zero) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else if (!enable) begin
              state_nxt = IDLE;
            end
          end else begin
            ps_nxt = ps + PW'(1);
            if (!enable) state_nxt = IDLE;
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, prescaler and time registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ps         <= '0;
      min_tens   <= 4'd0;
      min_ones   <= 4'd0;
      sec_tens   <= 4'd0;
      sec_ones   <= 4'd0;
      timer_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ps         <= ps_nxt;
      min_tens   <= mt_nxt;
      min_ones   <= mo_nxt;
      sec_tens   <= st_nxt;
      sec_ones   <= so_nxt;
      timer_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer at four clocks per second. A decimal-number model
// of the displayed MM:SS value is compared every cycle; directed checkpoints
// pin both the DUT and the model to hand-computed values.
module tb_countdown_timer;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clearn = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       enable = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       zero, timer_done;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // model: displayed value as a 4-digit decimal number MMSS
  int mv = 0;
  int mps = 0;
  bit mrun = 1'b0;
  bit mdone = 1'b0;

  countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst(rst), .clearn(clearn), .digit_valid(digit_valid),
    .digit(digit), .enable(enable), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .zero(zero), .timer_done(timer_done)
  );

  always #5 clk = ~clk;

  wire [15:0] dv = {min_tens, min_ones, sec_tens, sec_ones};

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int dec_val(int v);
    int m, s;
    m = v / 100;
    s = v % 100;
    if (s > 0) return v - 1;
    return (m - 1) * 100 + 59;
  endfunction

  task automatic chk(string name, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst || !clearn) begin
      mv = 0; mps = 0; mrun = 1'b0; mdone = 1'b0;
    end else if (digit_valid && digit <= 4'd9 && !enable) begin
      mv = (mv % 1000) * 10 + int'(digit);
      mdone = 1'b0;
      mrun = 1'b0;
    end else if (mrun) begin
      if (mps == T - 1) begin
        mps = 0;
        mv = dec_val(mv);
        if (mv == 0) begin
          mdone = 1'b1;
          mrun = 1'b0;
        end else begin
          mrun = enable;
        end
      end else begin
        mps++;
        mrun = enable;
      end
    end else if (!mdone && enable && mv != 0) begin
      mrun = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_digits", 32'(dv), 32'(to_bcd(mv)));
      chk("model_zero", 32'(zero), (mv == 0) ? 1 : 0);
      chk("model_done", 32'(timer_done), 32'(mdone));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int d);
    digit = 4'(d);
    digit_valid = 1'b1;
    step(1);
    digit_valid = 1'b0;
  endtask

  task automatic clr();
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
  endtask

  task automatic lit(string name, logic [15:0] exp_d, bit exp_done);
    chk({name, "_digits"}, 32'(dv), 32'(exp_d));
    chk({name, "_done"}, 32'(timer_done), 32'(exp_done));
  endtask

  initial begin
    step(2);
    lit("reset", 16'h0000, 1'b0);
    chk("reset_zero", 32'(zero), 1);
    rst = 1'b0;
    chk_on = 1'b1;

    press(1); press(3); press(0);
    lit("entry", 16'h0130, 1'b0);
    chk("entry_zero", 32'(zero), 0);
    chk("entry_model", mv, 130);

    clr(); press(1); press(0);
    enable = 1'b1;
    step(4);  lit("borrow_hold", 16'h0010, 1'b0);
    step(1);  lit("borrow_first", 16'h0009, 1'b0);
    step(35); lit("borrow_last1", 16'h0001, 1'b0);
    step(1);  lit("borrow_end", 16'h0000, 1'b1);
    enable = 1'b0;
    step(5);  lit("done_held", 16'h0000, 1'b1);

    press(1); press(0); press(0);
    lit("load_100", 16'h0100, 1'b0);
    enable = 1'b1;
    step(5);  lit("min_borrow", 16'h0059, 1'b0);
    chk("min_borrow_model", mv, 59);
    enable = 1'b0;
    step(1);
    clr(); press(9); press(0);
    enable = 1'b1;
    step(5);   lit("sec90_first", 16'h0089, 1'b0);
    step(355); lit("sec90_last1", 16'h0001, 1'b0);
    step(1);   lit("sec90_end", 16'h0000, 1'b1);
    enable = 1'b0;

    clr(); press(5);
    enable = 1'b1;
    step(4);  lit("pause_pre", 16'h0005, 1'b0);
    step(1);  lit("pause_first", 16'h0004, 1'b0);
    step(1);
    enable = 1'b0;
    step(10); lit("pause_hold", 16'h0004, 1'b0);
    enable = 1'b1;
    step(2);  lit("resume_pre", 16'h0004, 1'b0);
    step(1);  lit("resume_tick", 16'h0003, 1'b0);
    clr();    lit("clear_run", 16'h0000, 1'b0);
    step(10); lit("clear_quiet", 16'h0000, 1'b0);

    enable = 1'b0;
    press(1); press(2); press(3); press(4);
    lit("load_1234", 16'h1234, 1'b0);
    press(12); lit("reject_12", 16'h1234, 1'b0);
    enable = 1'b1;
    press(7);  lit("reject_en", 16'h1234, 1'b0);
    enable = 1'b0;
    step(1);
    press(5);  lit("fifth_digit", 16'h2345, 1'b0);
    chk("fifth_model", mv, 2345);

    clr(); press(1);
    enable = 1'b1;
    step(5);  lit("run_to_done", 16'h0000, 1'b1);
    step(3);  lit("done_enabled", 16'h0000, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    lit("rst_done", 16'h0000, 1'b0);
    step(10); lit("rst_quiet", 16'h0000, 1'b0);

    enable = 1'b0;
    press(1);
    enable = 1'b1;
    step(4);
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    lit("clear_on_tick", 16'h0000, 1'b0);
    step(3);  lit("clear_tick_quiet", 16'h0000, 1'b0);
    enable = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100, clock cycles per counted second (legal range 2 and up).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port clearn  input  1  active-low clear of time and done status.
REQ-005 SHALL have port digit_valid  input  1  one-cycle keypad digit strobe.
REQ-006 SHALL have port digit  input  4  keypad digit value (BCD).
REQ-007 SHALL have port enable  input  1  count enable, driven by the control stage's mag output.
REQ-008 SHALL have port min_tens, min_ones, sec_tens, sec_ones  output  4 each  registered BCD time digits.
REQ-009 SHALL have port zero  output  1  combinational; high when all four digits are 0.
REQ-010 SHALL have port timer_done  output  1  registered; feeds control.timer_done.

Function
REQ-011 SHALL implement internal states IDLE (not counting), RUN (counting), DONE (countdown completed).
REQ-012 SHALL apply priority per cycle: rst > clearn low > digit entry > counting.
REQ-013 SHALL accept a digit only when digit_valid=1, digit<=9 and enable=0.
REQ-014 SHALL ignore digits 10-15 and any digit arriving while enable=1, with no state change.
REQ-015 SHALL shift in an accepted digit: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit.
REQ-016 SHALL drop the old min_tens on an accepted digit; this is the overflow behaviour on a fifth digit.
REQ-017 SHALL clear timer_done and enter IDLE on an accepted digit.
REQ-018 SHALL, with clearn=0, zero all digits, the prescaler and timer_done, and enter IDLE.
REQ-019 SHALL go IDLE->RUN when enable=1 and zero=0; with enable=1 and zero=1, stay IDLE with timer_done unchanged.
REQ-020 SHALL run the prescaler only in RUN: count 0..TICKS_PER_SEC-1, wrap to 0, and issue a tick on the wrap cycle.
REQ-021 SHALL make the first decrement TICKS_PER_SEC cycles after RUN is entered from a zeroed prescaler.
REQ-022 SHALL go RUN->IDLE when enable=0 (pause); the prescaler and digits hold, and counting resumes from the held prescaler value.
REQ-023 SHALL decrement one second per tick: sec_ones-1 if nonzero.
REQ-024 SHALL otherwise set sec_ones=9 and decrement sec_tens if nonzero.
REQ-025 SHALL otherwise set sec_tens=5 and borrow from minutes: min_ones-1 if nonzero, else min_ones=9 and min_tens-1.
REQ-026 SHALL keep entered seconds above 59 (e.g. 0:90) valid: count 90, 89, ..., 00 with no normalisation.
REQ-027 SHALL, on the tick that makes the value 0000, go RUN->DONE, set timer_done=1 in the same clock edge, and zero the prescaler.
REQ-028 SHALL, in DONE, hold timer_done=1 and perform no counting regardless of enable, until clearn=0, an accepted digit, or rst.
REQ-029 SHALL, on clearn=0 coinciding with the final tick, leave digits 0, timer_done=0 and state IDLE.
REQ-030 SHALL never decrement below 0000 and never produce a non-BCD digit.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, force all digits 0, prescaler 0, timer_done=0 and state IDLE.
REQ-032 SHALL let rst override every other input, including mid-countdown, with counting restarting only after a new entry and enable.
REQ-033 SHALL leave zero=1 after reset, derived from the digits.

Verification (TICKS_PER_SEC=4)
REQ-034 SHALL cover entry: digits 1,3,0 strobed with enable=0 -> digits 0,1,3,0, zero=0, timer_done=0.
REQ-035 SHALL cover borrow: load 0:10, enable=1 -> 0:09 after 4 cycles, 0:00 after 40 cycles, timer_done=1 on that edge, held after enable drops.
REQ-036 SHALL cover minute borrow: load 1:00, enable=1 -> 0:59 after 4 cycles; load 0:90 -> 0:89 then ... 0:00 after 360 cycles.
REQ-037 SHALL cover pause: 0:05 with enable high 6 cycles, low 10, high again -> first decrement at cycle 4, second 2 cycles after re-enable.
REQ-038 SHALL cover rejection: digit=12 strobe and digit=7 strobe while enable=1 -> no change; fifth digit 5 into 12:34 -> 23:45.
REQ-039 SHALL cover clear/reset: clearn=0 mid-countdown, and separately rst=1 in DONE -> digits 0000, timer_done=0, no further ticks.
